// File: rtl/boom_mshr_replay_queue_pkg.sv
// Shared types for the MSHR replay queue: request payload, branch-update info,
// FSM state encoding, and the kill helpers used by the queue and its slots.
package boom_mshr_replay_queue_pkg;

    localparam int BR_W   = 4;
    localparam int ROB_W  = 8;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int CMD_W  = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        REPLAY = 2'd2
    } RpqStateE;

    typedef struct packed {
        logic [BR_W-1:0]  br_mask;
        logic [ROB_W-1:0] rob_idx;
        logic             uses_ldq;
        logic             uses_stq;
        logic             is_amo;
    } MicroOpST;

    typedef struct packed {
        MicroOpST          uop;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [CMD_W-1:0]  cmd;
        logic              is_hella;
    } BoomDCacheReqInternalST;

    typedef struct packed {
        logic [BR_W-1:0] resolve_mask;
        logic [BR_W-1:0] mispredict_mask;
    } BrUpdateInfoST;

    typedef struct packed {
        logic                   valid;
        BoomDCacheReqInternalST req;
    } RpqEntryST;

    function automatic logic isKilled(input logic [BR_W-1:0] br_mask,
                                      input BrUpdateInfoST  bru);
        return |(br_mask & bru.mispredict_mask);
    endfunction

    // Hella-cache requests are not pipeline loads and survive a flush.
    function automatic logic exceptionKills(input BoomDCacheReqInternalST req);
        return req.uop.uses_ldq && !req.is_hella;
    endfunction

endpackage

// File: rtl/boom_rpq_entry.sv
// One replay-queue slot: holds a request and tracks its branch mask and liveness.
// The slot keeps occupying its position after being killed until the head retires it.
module boom_rpq_entry
    import boom_mshr_replay_queue_pkg::*;
(
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   clear_i,
    input  logic                   alloc_i,
    input  BoomDCacheReqInternalST alloc_req_i,
    input  logic                   free_i,
    input  BrUpdateInfoST          brupdate_i,
    input  logic                   exception_i,
    output RpqEntryST              entry_o
);

    RpqEntryST entry_q, entry_d;

    always_comb begin
        entry_d = entry_q;
        if (alloc_i) begin
            entry_d.req             = alloc_req_i;
            entry_d.req.uop.br_mask = alloc_req_i.uop.br_mask & ~brupdate_i.resolve_mask;
            entry_d.valid           = !isKilled(alloc_req_i.uop.br_mask, brupdate_i)
                                      && !(exception_i && exceptionKills(alloc_req_i));
        end else begin
            entry_d.req.uop.br_mask = entry_q.req.uop.br_mask & ~brupdate_i.resolve_mask;
            if (free_i
                || isKilled(entry_q.req.uop.br_mask, brupdate_i)
                || (exception_i && exceptionKills(entry_q.req))) begin
                entry_d.valid = 1'b0;
            end
        end
        if (clear_i) begin
            entry_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/boom_mshr_replay_queue.sv
// Per-MSHR replay queue: buffers miss requests while the line refills, then replays
// them in strict FIFO order; speculative entries killed by branches/flushes retire silently.
module boom_mshr_replay_queue
    import boom_mshr_replay_queue_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     enq_valid_i,
    output logic                     enq_ready_o,
    input  BoomDCacheReqInternalST   enq_req_i,
    input  BrUpdateInfoST            brupdate_i,
    input  logic                     exception_i,
    input  logic                     refill_done_i,
    input  logic                     mshr_clear_i,
    output logic                     replay_valid_o,
    input  logic                     replay_ready_i,
    output BoomDCacheReqInternalST   replay_req_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     dirties_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    RpqStateE         state_q, state_d;
    logic             refilled_q, refilled_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    RpqEntryST entries [DEPTH];
    RpqEntryST head_entry;
    logic      full, nonempty, enq_fire, head_live, in_replay, retire;

    always_comb begin
        head_entry     = entries[head_q];
        full           = (count_q == CNT_W'(DEPTH));
        nonempty       = (count_q != '0);
        enq_ready_o    = !full && !mshr_clear_i;
        enq_fire       = enq_valid_i && enq_ready_o;
        // A head killed this cycle is hidden now and retired silently next cycle.
        head_live      = head_entry.valid
                         && !isKilled(head_entry.req.uop.br_mask, brupdate_i)
                         && !(exception_i && exceptionKills(head_entry.req));
        in_replay      = (state_q == REPLAY) && nonempty && !mshr_clear_i;
        replay_valid_o = in_replay && head_live;
        retire         = in_replay && (!head_entry.valid || (head_live && replay_ready_i));
        replay_req_o   = head_entry.req;
        replay_req_o.uop.br_mask = head_entry.req.uop.br_mask & ~brupdate_i.resolve_mask;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        boom_rpq_entry u_entry (
            .clock_i     (clock_i),
            .reset_i     (reset_i),
            .clear_i     (mshr_clear_i),
            .alloc_i     (enq_fire && (tail_q == PTR_W'(g))),
            .alloc_req_i (enq_req_i),
            .free_i      (retire && (head_q == PTR_W'(g))),
            .brupdate_i  (brupdate_i),
            .exception_i (exception_i),
            .entry_o     (entries[g])
        );
    end

    always_comb begin
        if (mshr_clear_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(retire);
            tail_d  = tail_q + PTR_W'(enq_fire);
            count_d = count_q + CNT_W'(enq_fire) - CNT_W'(retire);
        end
    end

    always_comb begin
        state_d    = state_q;
        refilled_d = refilled_q;
        case (state_q)
            IDLE: begin
                if (refill_done_i) refilled_d = 1'b1;
                if (enq_fire) state_d = (refilled_q || refill_done_i) ? REPLAY : WAIT;
            end
            WAIT: begin
                if (refill_done_i) begin
                    refilled_d = 1'b1;
                    state_d    = REPLAY;
                end
            end
            REPLAY: begin
                if (refill_done_i) refilled_d = 1'b1;
                if (count_d == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (mshr_clear_i) begin
            state_d    = IDLE;
            refilled_d = 1'b0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            refilled_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            refilled_q <= refilled_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        dirties_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            dirties_o |= entries[i].valid
                         && (entries[i].req.uop.uses_stq || entries[i].req.uop.is_amo);
        end
    end

    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: tb/tb_boom_mshr_replay_queue.sv
// Directed bench for the MSHR replay queue: ordering, kills, resolve, full/wrap,
// flush handling and clear.
module tb_boom_mshr_replay_queue;
    import boom_mshr_replay_queue_pkg::*;

    logic                   clock;
    logic                   reset;
    logic                   enq_valid;
    logic                   enq_ready;
    BoomDCacheReqInternalST enq_req;
    BrUpdateInfoST          brupdate;
    logic                   exception;
    logic                   refill_done;
    logic                   mshr_clear;
    logic                   replay_valid;
    logic                   replay_ready;
    BoomDCacheReqInternalST replay_req;
    logic [4:0]             count;
    logic                   empty;
    logic                   dirties;

    int total = 0;
    int bad   = 0;

    boom_mshr_replay_queue #(.DEPTH(16)) dut (
        .clock_i        (clock),
        .reset_i        (reset),
        .enq_valid_i    (enq_valid),
        .enq_ready_o    (enq_ready),
        .enq_req_i      (enq_req),
        .brupdate_i     (brupdate),
        .exception_i    (exception),
        .refill_done_i  (refill_done),
        .mshr_clear_i   (mshr_clear),
        .replay_valid_o (replay_valid),
        .replay_ready_i (replay_ready),
        .replay_req_o   (replay_req),
        .count_o        (count),
        .empty_o        (empty),
        .dirties_o      (dirties)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic BoomDCacheReqInternalST mk(input logic [7:0] id, input logic [3:0] br,
                                                  input logic ldq, input logic stq);
        BoomDCacheReqInternalST r;
        r = '0;
        r.uop.rob_idx  = id;
        r.uop.br_mask  = br;
        r.uop.uses_ldq = ldq;
        r.uop.uses_stq = stq;
        r.addr         = {24'h0, id};
        r.cmd          = stq ? 5'd1 : 5'd0;
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_clear();
        mshr_clear = 1'b1;
        tick();
        mshr_clear = 1'b0;
    endtask

    task automatic enq(input BoomDCacheReqInternalST r);
        enq_valid = 1'b1;
        enq_req   = r;
        tick();
        enq_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++; if (enq_ready !== 1'b1) begin bad++; $display("FAIL reset_enq_ready got=%0b want=1", enq_ready); end
        total++; if (replay_valid !== 1'b0) begin bad++; $display("FAIL reset_replay_valid got=%0b want=0", replay_valid); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b want=1", empty); end
        total++; if (dirties !== 1'b0) begin bad++; $display("FAIL reset_dirties got=%0b want=0", dirties); end
        total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    endtask

    task automatic test_basic_replay();
        logic [7:0] ids [3];
        ids[0] = 8'hA; ids[1] = 8'hB; ids[2] = 8'hC;
        for (int i = 0; i < 3; i++) enq(mk(ids[i], 4'b0000, 1'b1, 1'b0));
        #1;
        total++; if (count !== 5'd3) begin bad++; $display("FAIL basic_count got=%0d want=3", count); end
        tick(); tick(); #1;
        total++; if (replay_valid !== 1'b0) begin bad++; $display("FAIL basic_wait_rv got=%0b want=0", replay_valid); end
        refill_done = 1'b1;
        tick();
        refill_done  = 1'b0;
        replay_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (replay_valid !== 1'b1 || replay_req.uop.rob_idx !== ids[i])
                begin bad++; $display("FAIL basic_replay%0d got=v%0b/%0h want=v1/%0h", i, replay_valid, replay_req.uop.rob_idx, ids[i]); end
            tick();
        end
        #1;
        total++; if (count !== 5'd0 || empty !== 1'b1 || replay_valid !== 1'b0)
            begin bad++; $display("FAIL basic_drain got=c%0d e%0b v%0b want=c0 e1 v0", count, empty, replay_valid); end
        replay_ready = 1'b0;
    endtask

    task automatic test_mispredict();
        do_clear();
        enq(mk(8'h01, 4'b0010, 1'b1, 1'b0));
        enq(mk(8'h02, 4'b0000, 1'b1, 1'b0));
        brupdate.mispredict_mask = 4'b0010;
        tick();
        brupdate = '0;
        #1;
        total++; if (count !== 5'd2) begin bad++; $display("FAIL misp_count got=%0d want=2", count); end
        refill_done = 1'b1;
        tick();
        refill_done  = 1'b0;
        replay_ready = 1'b1;
        #1;
        total++; if (replay_valid !== 1'b0) begin bad++; $display("FAIL misp_dead_head got=%0b want=0", replay_valid); end
        tick(); #1;
        total++; if (count !== 5'd1 || replay_valid !== 1'b1 || replay_req.uop.rob_idx !== 8'h02)
            begin bad++; $display("FAIL misp_b got=c%0d v%0b id%0h want=c1 v1 id02", count, replay_valid, replay_req.uop.rob_idx); end
        tick(); #1;
        total++; if (count !== 5'd0) begin bad++; $display("FAIL misp_drain got=%0d want=0", count); end
        replay_ready = 1'b0;
    endtask

    task automatic test_resolve();
        do_clear();
        enq(mk(8'h03, 4'b0011, 1'b1, 1'b0));
        brupdate.resolve_mask = 4'b0010;
        #1;
        total++; if (replay_req.uop.br_mask !== 4'b0001) begin bad++; $display("FAIL resolve_comb got=%b want=0001", replay_req.uop.br_mask); end
        tick();
        brupdate = '0;
        #1;
        total++; if (replay_req.uop.br_mask !== 4'b0001) begin bad++; $display("FAIL resolve_stored got=%b want=0001", replay_req.uop.br_mask); end
        refill_done = 1'b1;
        tick();
        refill_done  = 1'b0;
        replay_ready = 1'b1;
        #1;
        total++; if (replay_valid !== 1'b1 || replay_req.uop.rob_idx !== 8'h03)
            begin bad++; $display("FAIL resolve_kept got=v%0b id%0h want=v1 id03", replay_valid, replay_req.uop.rob_idx); end
        tick(); #1;
        total++; if (count !== 5'd0) begin bad++; $display("FAIL resolve_drain got=%0d want=0", count); end
        replay_ready = 1'b0;
    endtask

    task automatic test_full_wrap();
        logic [7:0] id;
        do_clear();
        for (int i = 0; i < 16; i++) enq(mk(8'h10 + 8'(i), 4'b0000, 1'b1, 1'b0));
        enq_valid = 1'b1;
        enq_req   = mk(8'h20, 4'b0000, 1'b1, 1'b0);
        #1;
        total++; if (enq_ready !== 1'b0 || count !== 5'd16)
            begin bad++; $display("FAIL full_state got=r%0b c%0d want=r0 c16", enq_ready, count); end
        tick(); #1;
        total++; if (count !== 5'd16) begin bad++; $display("FAIL full_reject got=%0d want=16", count); end
        enq_valid   = 1'b0;
        refill_done = 1'b1;
        tick();
        refill_done  = 1'b0;
        replay_ready = 1'b1;
        enq_valid    = 1'b1;
        #1;
        total++; if (enq_ready !== 1'b0 || replay_req.uop.rob_idx !== 8'h10)
            begin bad++; $display("FAIL full_first got=r%0b id%0h want=r0 id10", enq_ready, replay_req.uop.rob_idx); end
        tick(); #1;
        total++; if (count !== 5'd15 || enq_ready !== 1'b1 || replay_req.uop.rob_idx !== 8'h11)
            begin bad++; $display("FAIL full_second got=c%0d r%0b id%0h want=c15 r1 id11", count, enq_ready, replay_req.uop.rob_idx); end
        tick();
        enq_valid = 1'b0;
        #1;
        total++; if (count !== 5'd15) begin bad++; $display("FAIL enq_retire_count got=%0d want=15", count); end
        for (int k = 0; k < 15; k++) begin
            id = (k < 14) ? 8'h12 + 8'(k) : 8'h20;
            #1;
            total++; if (replay_valid !== 1'b1 || replay_req.uop.rob_idx !== id)
                begin bad++; $display("FAIL wrap_order%0d got=v%0b id%0h want=v1 id%0h", k, replay_valid, replay_req.uop.rob_idx, id); end
            tick();
        end
        #1;
        total++; if (count !== 5'd0) begin bad++; $display("FAIL wrap_drain got=%0d want=0", count); end
        replay_ready = 1'b0;
    endtask

    task automatic test_exception();
        do_clear();
        enq(mk(8'h31, 4'b0000, 1'b1, 1'b0));
        enq(mk(8'h32, 4'b0000, 1'b0, 1'b1));
        enq(mk(8'h33, 4'b0000, 1'b1, 1'b0));
        #1;
        total++; if (dirties !== 1'b1 || count !== 5'd3)
            begin bad++; $display("FAIL exc_pre got=d%0b c%0d want=d1 c3", dirties, count); end
        exception = 1'b1;
        tick();
        exception = 1'b0;
        #1;
        total++; if (dirties !== 1'b1 || count !== 5'd3)
            begin bad++; $display("FAIL exc_post got=d%0b c%0d want=d1 c3", dirties, count); end
        refill_done = 1'b1;
        tick();
        refill_done  = 1'b0;
        replay_ready = 1'b1;
        #1;
        total++; if (replay_valid !== 1'b0) begin bad++; $display("FAIL exc_load1 got=%0b want=0", replay_valid); end
        tick(); #1;
        total++; if (replay_valid !== 1'b1 || replay_req.uop.rob_idx !== 8'h32)
            begin bad++; $display("FAIL exc_store got=v%0b id%0h want=v1 id32", replay_valid, replay_req.uop.rob_idx); end
        tick(); #1;
        total++; if (replay_valid !== 1'b0 || count !== 5'd1 || dirties !== 1'b0)
            begin bad++; $display("FAIL exc_load2 got=v%0b c%0d d%0b want=v0 c1 d0", replay_valid, count, dirties); end
        tick(); #1;
        total++; if (count !== 5'd0) begin bad++; $display("FAIL exc_drain got=%0d want=0", count); end
        replay_ready = 1'b0;
    endtask

    task automatic test_clear();
        do_clear();
        enq(mk(8'h41, 4'b0000, 1'b1, 1'b0));
        refill_done = 1'b1;
        tick();
        refill_done = 1'b0;
        #1;
        total++; if (replay_valid !== 1'b1) begin bad++; $display("FAIL clr_replaying got=%0b want=1", replay_valid); end
        mshr_clear = 1'b1;
        enq_valid  = 1'b1;
        enq_req    = mk(8'h42, 4'b0000, 1'b1, 1'b0);
        #1;
        total++; if (enq_ready !== 1'b0 || replay_valid !== 1'b0)
            begin bad++; $display("FAIL clr_same_cycle got=r%0b v%0b want=r0 v0", enq_ready, replay_valid); end
        tick();
        mshr_clear = 1'b0;
        enq_valid  = 1'b0;
        #1;
        total++; if (count !== 5'd0 || empty !== 1'b1)
            begin bad++; $display("FAIL clr_after got=c%0d e%0b want=c0 e1", count, empty); end
        enq(mk(8'h42, 4'b0000, 1'b1, 1'b0));
        replay_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (replay_valid !== 1'b0) begin bad++; $display("FAIL clr_needs_refill%0d got=%0b want=0", i, replay_valid); end
            tick();
        end
        total++; if (count !== 5'd1) begin bad++; $display("FAIL clr_held got=%0d want=1", count); end
        refill_done = 1'b1;
        tick();
        refill_done = 1'b0;
        #1;
        total++; if (replay_valid !== 1'b1 || replay_req.uop.rob_idx !== 8'h42)
            begin bad++; $display("FAIL clr_replay got=v%0b id%0h want=v1 id42", replay_valid, replay_req.uop.rob_idx); end
        tick(); #1;
        total++; if (count !== 5'd0) begin bad++; $display("FAIL clr_drain got=%0d want=0", count); end
        replay_ready = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        enq_valid    = 1'b0;
        enq_req      = '0;
        brupdate     = '0;
        exception    = 1'b0;
        refill_done  = 1'b0;
        mshr_clear   = 1'b0;
        replay_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        test_reset();
        test_basic_replay();
        test_mispredict();
        test_resolve();
        test_full_wrap();
        test_exception();
        test_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
